dcache_pmem_burst_adapter: RTL
==============================

// Module: dcache_pmem_burst_adapter
// PURPOSE
//  Responder end of the data cache's physical-memory (pmem) interface. Accepts whole-line
//  pmem_read/pmem_write requests from the data cache and serialises them into BEATS-beat
//  bursts on a narrow memory port. Answers each request with a one-cycle pmem_resp.
//  Sits between the data cache and the memory/arbiter burst port.
// PARAMETERS
//  ADDR_WIDTH   32   byte address width
//  OFFSET_BITS  5    log2(bytes per cacheline); burst_address has these bits forced to 0
//  LINE_WIDTH   256  cacheline width in bits, = 8*2**OFFSET_BITS
//  BURST_WIDTH  64   beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH (4), integer >=2
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst            in   1           asynchronous, active-high reset
//  pmem_address   in   ADDR_WIDTH  line address from cache, held until pmem_resp
//  pmem_read      in   1           line read request, level, held until pmem_resp
//  pmem_write     in   1           line write request, level, held until pmem_resp
//  pmem_wdata     in   LINE_WIDTH  write line, valid while pmem_write
//  pmem_rdata     out  LINE_WIDTH  read line, valid when pmem_resp follows a read
//  pmem_resp      out  1           one-cycle completion pulse
//  burst_address  out  ADDR_WIDTH  line-aligned address, stable for the whole burst
//  burst_read     out  1           burst read request, high for all beats
//  burst_write    out  1           burst write request, high for all beats
//  burst_wdata    out  BURST_WIDTH current write beat
//  burst_rdata    in   BURST_WIDTH read beat, valid when burst_resp
//  burst_resp     in   1           per-beat acknowledge; one beat per cycle it is high
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; beat counter 0; line buffers 0.
//  FSM states: IDLE, READ, WRITE, DONE.
//   IDLE:
//    - pmem_read=1: latch {pmem_address[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'0}; go READ.
//    - Else pmem_write=1: latch the aligned address and pmem_wdata; go WRITE.
//    - Both high: read wins; the write is served after the read completes if still held.
//   READ:
//    - burst_read=1.
//    - On each burst_resp: rbuf[cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_rdata; cnt++.
//    - On the beat with cnt==BEATS-1: cnt<=0, go DONE.
//   WRITE:
//    - burst_write=1; burst_wdata = wbuf[cnt*BURST_WIDTH +: BURST_WIDTH].
//    - cnt advances on burst_resp; after beat BEATS-1: cnt<=0, go DONE.
//   DONE: pmem_resp=1 for exactly one cycle, then IDLE.
//  Beat order: beat 0 = line bits [BURST_WIDTH-1:0] (lowest address first).
//  Latency: request sampled in IDLE at edge N; burst_* asserted from cycle N+1.
//   With back-to-back burst_resp, pmem_resp is high in cycle N+1+BEATS.
//   An IDLE->IDLE turnaround is at least one cycle after DONE.
//  Boundary conditions:
//   - burst_resp gaps (low cycles) stall cnt; burst_* outputs and burst_address hold.
//   - burst_resp while IDLE or DONE is ignored (no counter or buffer change).
//   - pmem_rdata = rbuf, registered. Changes only on READ beats; stable from DONE until
//     the next read's first beat. Writes never alter rbuf.
//   - pmem_address/pmem_wdata changes after latching are ignored until the next IDLE.
//   - rst mid-burst: immediate return to IDLE, cnt=0, burst_read/burst_write/pmem_resp
//     drop asynchronously; the pending request is re-sampled after rst releases.
//   - Counter width is $clog2(BEATS); cnt is never allowed to exceed BEATS-1.
// TESTING
//  1 Read 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44
//    back-to-back -> burst_address=0x0000_1220; pmem_resp one cycle in cycle 6;
//    pmem_rdata={44..,33..,22..,11..}.
//  2 Write line 0xDDDD..CCCC..BBBB..AAAA (64-bit lanes) to 0x8000_0040 ->
//    burst_wdata sequence AAAA.., BBBB.., CCCC.., DDDD..; one pmem_resp; rbuf unchanged.
//  3 Read with burst_resp pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order;
//    pmem_resp one cycle after the 4th beat; burst_address stable throughout.
//  4 pmem_read and pmem_write both high in IDLE -> read burst first, then the write
//    burst if pmem_write is still held.
//  5 Assert rst after beat 2 of a write -> burst_write=0 immediately; state IDLE;
//    held pmem_write restarts from beat 0 after release.
//  6 Stray burst_resp pulses while IDLE -> no pmem_resp, pmem_rdata unchanged.

Source files
------------

// File: rtl/dcache_pmem_burst_adapter.sv
// dcache_pmem_burst_adapter: serialises whole-line pmem read/write requests into
// fixed-length beat bursts on a narrow memory port, answering with a one-cycle pmem_resp.
module dcache_pmem_burst_adapter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 5,
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  pmem_address,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic                   pmem_resp,
    output logic [ADDR_WIDTH-1:0]  burst_address,
    output logic                   burst_read,
    output logic                   burst_write,
    output logic [BURST_WIDTH-1:0] burst_wdata,
    input  logic [BURST_WIDTH-1:0] burst_rdata,
    input  logic                   burst_resp
);
    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CW = $clog2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [LINE_WIDTH-1:0] r_wbuf;
    // pmem_rdata doubles as the read line buffer, so it only moves on read beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_wbuf        <= '0;
            pmem_rdata    <= '0;
            pmem_resp     <= 1'b0;
            burst_address <= '0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pmem_read) begin
                        burst_address <= pmem_address & ALIGN;
                        burst_read    <= 1'b1;
                        r_state       <= READ;
                    end else if (pmem_write) begin
                        burst_address <= pmem_address & ALIGN;
                        r_wbuf        <= pmem_wdata;
                        burst_write   <= 1'b1;
                        r_state       <= WRITE;
                    end
                end
                READ: begin
                    if (burst_resp) begin
                        pmem_rdata[r_cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_rdata;
                        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            burst_read <= 1'b0;
                            pmem_resp  <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (burst_resp) begin
                        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            burst_write <= 1'b0;
                            pmem_resp   <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                default: begin
                    pmem_resp <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end
    assign burst_wdata = r_wbuf[r_cnt*BURST_WIDTH +: BURST_WIDTH];
endmodule
